// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bus bundle shared by the two master ports and the SDRAM slave port.
// "master" is the side that issues requests; "slave" is the side that answers them.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter for the SDRAM controller port, with lock-until-accept
// and a small ID FIFO that steers pipelined read responses back to their issuer.
//
// state    | meaning
// ST_OPEN  | no stalled transfer; grant chosen by request/round-robin
// ST_LOCK0 | m0 transfer stalled by the slave; grant pinned to m0
// ST_LOCK1 | m1 transfer stalled by the slave; grant pinned to m1
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  sdram_port_arbiter_if.slave   m0,
  sdram_port_arbiter_if.slave   m1,
  sdram_port_arbiter_if.master  s,
  output logic                  err_orphan
);

  localparam int PTR_W = $clog2(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_OPEN  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_rst_sync;
  logic                   r_last;
  logic [MAX_PENDING-1:0] r_fifo_id;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic                   r_err_orphan;

  logic w_rst_done;
  logic w_full;
  logic w_empty;
  logic w_req0;
  logic w_req1;
  logic w_sel;
  logic w_reqsel;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head_id;

  assign w_rst_done = r_rst_sync[1];
  assign w_full     = (r_count == (PTR_W+1)'(MAX_PENDING));
  assign w_empty    = (r_count == '0);
  // A read is only eligible while a response slot is free; writes never wait on the FIFO.
  assign w_req0     = w_rst_done & (m0.write | (m0.read & ~w_full));
  assign w_req1     = w_rst_done & (m1.write | (m1.read & ~w_full));
  assign w_reqsel   = w_sel ? w_req1 : w_req0;
  assign w_accept   = w_reqsel & ~s.waitrequest;
  assign w_push     = w_accept & s.read;
  assign w_pop      = s.readdatavalid & ~w_empty;
  assign w_head_id  = r_fifo_id[r_rd_ptr];
  assign err_orphan = r_err_orphan;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= ST_OPEN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A dropped request also releases the lock so a misbehaving master cannot wedge the port.
  always_comb begin
    w_state_nxt = ST_OPEN;
    if (w_reqsel && s.waitrequest) begin
      w_state_nxt = w_sel ? ST_LOCK1 : ST_LOCK0;
    end
  end

  always_comb begin
    w_sel = 1'b0;
    case (r_state)
      ST_LOCK0: w_sel = 1'b0;
      ST_LOCK1: w_sel = 1'b1;
      default: begin
        if (w_req0 && w_req1) begin
          w_sel = ~r_last;
        end else begin
          w_sel = w_req1;
        end
      end
    endcase
  end

  always_comb begin
    s.address          = w_sel ? m1.address    : m0.address;
    s.writedata        = w_sel ? m1.writedata  : m0.writedata;
    s.byteenable       = w_sel ? m1.byteenable : m0.byteenable;
    s.read             = w_reqsel & (w_sel ? m1.read  : m0.read);
    s.write            = w_reqsel & (w_sel ? m1.write : m0.write);
    m0.waitrequest     = ~(w_reqsel & ~w_sel) | s.waitrequest;
    m1.waitrequest     = ~(w_reqsel &  w_sel) | s.waitrequest;
    m0.readdata        = s.readdata;
    m1.readdata        = s.readdata;
    m0.readdatavalid   = w_pop & ~w_head_id;
    m1.readdatavalid   = w_pop &  w_head_id;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_last       <= 1'b1;
      r_fifo_id    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last <= w_sel;
      end
      if (w_push) begin
        r_fifo_id[r_wr_ptr] <= w_sel;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s.readdatavalid && w_empty) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

endmodule
